cp0_reg: RTL and testbench

- Coprocessor-0 register file for the MIPS core.
- Consumes the 32-bit exception code produced by the memory-stage exception logic and records exception state: EPC, Cause.ExcCode/BD, Status.EXL, BadVAddr.
- Services mtc0/mfc0 and runs the Count/Compare timer.
- Returns epc_o to the exception redirect logic and int_pending to the exception encoder. It is the receiving end of the exception path.

---
 rtl/cp0_reg_pkg.sv | 56 +++++
 rtl/cp0_timer.sv | 44 ++++
 rtl/cp0_reg.sv | 108 ++++++++++
 tb/tb_cp0_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// CP0 register numbers, field positions and exception codes.
// The exception encoder uses the same except_type encoding.
package cp0_reg_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    logic       badv;
  } exc_dec_t;

  function automatic exc_dec_t exc_decode(input logic [31:0] t);
    exc_dec_t d;
    d = '0;
    case (t)
      EXC_INT:  begin d.valid = 1'b1; d.code = EXCCODE_INT;  end
      EXC_ADEL: begin d.valid = 1'b1; d.code = EXCCODE_ADEL; d.badv = 1'b1; end
      EXC_ADES: begin d.valid = 1'b1; d.code = EXCCODE_ADES; d.badv = 1'b1; end
      EXC_SYS:  begin d.valid = 1'b1; d.code = EXCCODE_SYS;  end
      EXC_BP:   begin d.valid = 1'b1; d.code = EXCCODE_BP;   end
      EXC_RI:   begin d.valid = 1'b1; d.code = EXCCODE_RI;   end
      EXC_OV:   begin d.valid = 1'b1; d.code = EXCCODE_OV;   end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided Count, Compare register and sticky TI.
// ti_nxt is exported so Cause.IP[7] can latch TI on the same edge as TI itself.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti,
  output logic        ti_nxt
);

  logic [0:0] div;
  logic       div_wrap;

  assign div_wrap = (div == 1'(COUNT_DIV - 1));
  // Compare write clears TI even when a match is detected that cycle
  assign ti_nxt   = compare_we ? 1'b0
                  : (ti | ((count == compare) && (compare != 32'h0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      div     <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else begin
        div <= div_wrap ? 1'b0 : div + 1'b1;
        if (div_wrap) count <= count + 32'd1;
      end
      if (compare_we) compare <= wdata;
      ti <= ti_nxt;
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: records exception state, services mtc0/mfc0
// and produces the enabled-interrupt-pending flag for the exception encoder.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  ext_int,
  input  logic [31:0] except_type,
  input  logic [31:0] pc_exc,
  input  logic        is_in_delayslot,
  input  logic [31:0] bad_addr,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        int_pending,
  output logic        timer_int
);

  logic [31:0] status_r, epc_r, badv_r, count, compare;
  logic        cause_bd;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic        ti, ti_nxt;
  exc_dec_t    dec;
  logic        exc, eret, exl;

  assign dec  = exc_decode(except_type);
  assign exc  = dec.valid;
  assign eret = (except_type == EXC_ERET);
  assign exl  = status_r[STATUS_EXL];

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we && waddr == REG_COUNT),
    .compare_we (we && waddr == REG_COMPARE),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti),
    .ti_nxt     (ti_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status_r  <= STATUS_RESET;
      epc_r     <= '0;
      badv_r    <= '0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
    end else begin
      // Exception/eret own Status.EXL; a same-cycle mtc0 Status is dropped
      if (exc)
        status_r[STATUS_EXL] <= 1'b1;
      else if (eret)
        status_r[STATUS_EXL] <= 1'b0;
      else if (we && waddr == REG_STATUS)
        status_r <= (status_r & ~STATUS_WMASK) | (wdata & STATUS_WMASK);

      if (exc) begin
        cause_exc <= dec.code;
        if (!exl) cause_bd <= is_in_delayslot;
      end else if (we && waddr == REG_CAUSE) begin
        cause_ip[1:0] <= wdata[9:8];
      end
      cause_ip[7:2] <= {ext_int[5] | ti_nxt, ext_int[4:0]};

      // With EXL already set the exception leaves EPC alone, so mtc0 may land
      if (exc && !exl)
        epc_r <= is_in_delayslot ? pc_exc - 32'd4 : pc_exc;
      else if (we && waddr == REG_EPC)
        epc_r <= wdata;

      if (exc && dec.badv) badv_r <= bad_addr;
    end
  end

  assign epc_o       = epc_r;
  assign status_o    = status_r;
  assign cause_o     = {cause_bd, ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b0};
  assign timer_int   = ti;
  assign int_pending = status_r[STATUS_IE] & ~status_r[STATUS_EXL]
                     & (|(cause_ip & status_r[15:8]));

  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = badv_r;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status_r;
      REG_CAUSE:    rdata = cause_o;
      REG_EPC:      rdata = epc_r;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Scenario bench for cp0_reg: expected values are queued as stimulus is
// driven and popped when the resulting outputs are sampled.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [5:0]  ext_int = '0;
  logic [31:0] except_type = '0;
  logic [31:0] pc_exc = '0;
  logic        is_in_delayslot = 1'b0;
  logic [31:0] bad_addr = '0;
  logic [31:0] epc_o, status_o, cause_o;
  logic        int_pending, timer_int;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .ext_int(ext_int),
    .except_type(except_type), .pc_exc(pc_exc),
    .is_in_delayslot(is_in_delayslot), .bad_addr(bad_addr),
    .epc_o(epc_o), .status_o(status_o), .cause_o(cause_o),
    .int_pending(int_pending), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 1'b0; except_type = 32'h0; is_in_delayslot = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; sb.push_back(32'h0040_0000); sb.push_back(32'h0); sb.push_back(32'h0);
    sb.push_back(32'h0); sb.push_back(32'h0);
    tick(); raddr = 5'd9; #1;
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL reset_status got %h want %h", status_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL reset_cause got %h want %h", cause_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL reset_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if ({31'b0, int_pending} !== e) $display("FAIL reset_intp got %h want %h", int_pending, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL reset_count got %h want %h", rdata, e); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_syscall();
    except_type = 32'h8; pc_exc = 32'hbfc0_1000; is_in_delayslot = 1'b0;
    sb.push_back(32'hbfc0_1000); sb.push_back(32'h0000_0020); sb.push_back(32'h0040_0002);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL sys_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL sys_cause got %h want %h", cause_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL sys_status got %h want %h", status_o, e); else n_pass++;
    except_type = 32'he; sb.push_back(32'h0040_0000);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL sys_eret got %h want %h", status_o, e); else n_pass++;
  endtask

  task automatic test_adel_eret();
    except_type = 32'h4; pc_exc = 32'h8000_0010; is_in_delayslot = 1'b1; bad_addr = 32'h3;
    sb.push_back(32'h8000_000c); sb.push_back(32'h8000_0010); sb.push_back(32'h3);
    tick(); idle(); raddr = 5'd8; #1;
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL adel_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL adel_cause got %h want %h", cause_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL adel_badv got %h want %h", rdata, e); else n_pass++;
    except_type = 32'he; sb.push_back(32'h0040_0000); sb.push_back(32'h8000_000c);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL adel_eret_status got %h want %h", status_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL adel_eret_epc got %h want %h", epc_o, e); else n_pass++;
  endtask

  task automatic test_nested();
    except_type = 32'h5; pc_exc = 32'h300; is_in_delayslot = 1'b1; bad_addr = 32'h55;
    sb.push_back(32'h2fc); sb.push_back(32'h8000_0014);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL ades_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL ades_cause got %h want %h", cause_o, e); else n_pass++;
    except_type = 32'hc; pc_exc = 32'h100; is_in_delayslot = 1'b0; bad_addr = 32'hdead;
    sb.push_back(32'h2fc); sb.push_back(32'h8000_0030); sb.push_back(32'h55);
    tick(); idle(); raddr = 5'd8; #1;
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL nest_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL nest_cause got %h want %h", cause_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL nest_badv got %h want %h", rdata, e); else n_pass++;
    except_type = 32'he; sb.push_back(32'h0040_0000);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL nest_eret got %h want %h", status_o, e); else n_pass++;
  endtask

  task automatic test_masks();
    mtc0(5'd12, 32'hffff_ffff); sb.push_back(32'h0040_ff03);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL status_mask got %h want %h", status_o, e); else n_pass++;
    mtc0(5'd13, 32'hffff_ffff); sb.push_back(32'h8000_0330);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL cause_mask got %h want %h", cause_o, e); else n_pass++;
    mtc0(5'd13, 32'h0); tick();
    mtc0(5'd12, 32'h0000_0401); ext_int = 6'b000001;
    sb.push_back(32'h0040_0401); sb.push_back(32'h8000_0430); sb.push_back(32'h1);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL ie_status got %h want %h", status_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL hw_ip got %h want %h", cause_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if ({31'b0, int_pending} !== e) $display("FAIL hw_intp got %h want %h", int_pending, e); else n_pass++;
    mtc0(5'd12, 32'h0); ext_int = 6'b0; sb.push_back(32'h0);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if ({31'b0, int_pending} !== e) $display("FAIL hw_intp_off got %h want %h", int_pending, e); else n_pass++;
    mtc0(5'd8, 32'hdead_beef); tick();
    mtc0(5'd3, 32'h1234_5678); sb.push_back(32'h55); sb.push_back(32'h0);
    tick(); idle(); raddr = 5'd8; #1;
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL badv_ro got %h want %h", rdata, e); else n_pass++;
    raddr = 5'd3; #1;
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL unimpl_rd got %h want %h", rdata, e); else n_pass++;
  endtask

  task automatic test_timer();
    int cyc;
    mtc0(5'd12, 32'h0000_8001); tick();
    mtc0(5'd9, 32'h0); tick(); cyc = 0;
    mtc0(5'd11, 32'h5); tick(); idle(); cyc++;
    // Count reaches 5 ten edges after its write; TI latches one edge later
    sb.push_back(32'd11); sb.push_back(32'h1); sb.push_back(32'hc000_8030);
    while (!timer_int && cyc < 40) begin tick(); cyc++; end
    e = sb.pop_front(); n_chk++; if (cyc !== e) $display("FAIL ti_latency got %0d want %0d", cyc, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if ({31'b0, int_pending} !== e) $display("FAIL ti_intp got %h want %h", int_pending, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL ti_cause got %h want %h", cause_o, e); else n_pass++;
    sb.push_back(32'h1);
    repeat (4) tick();
    e = sb.pop_front(); n_chk++; if ({31'b0, timer_int} !== e) $display("FAIL ti_sticky got %h want %h", timer_int, e); else n_pass++;
    mtc0(5'd11, 32'h20); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h8000_0030);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if ({31'b0, timer_int} !== e) $display("FAIL ti_clear got %h want %h", timer_int, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if ({31'b0, int_pending} !== e) $display("FAIL ti_clear_intp got %h want %h", int_pending, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL ti_clear_cause got %h want %h", cause_o, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    mtc0(5'd14, 32'h1234); except_type = 32'h9; pc_exc = 32'h40; is_in_delayslot = 1'b0;
    sb.push_back(32'h40); sb.push_back(32'h0000_0024); sb.push_back(32'h0040_8003);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL prio_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (cause_o !== e) $display("FAIL prio_cause got %h want %h", cause_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL prio_status got %h want %h", status_o, e); else n_pass++;
    mtc0(5'd14, 32'h1234); except_type = 32'he;
    sb.push_back(32'h1234); sb.push_back(32'h0040_8001);
    tick(); idle();
    e = sb.pop_front(); n_chk++; if (epc_o !== e) $display("FAIL eret_mtc0_epc got %h want %h", epc_o, e); else n_pass++;
    e = sb.pop_front(); n_chk++; if (status_o !== e) $display("FAIL eret_mtc0_status got %h want %h", status_o, e); else n_pass++;
  endtask

  task automatic test_wrap();
    mtc0(5'd9, 32'hffff_ffff); sb.push_back(32'hffff_ffff); sb.push_back(32'hffff_ffff); sb.push_back(32'h0);
    tick(); idle(); raddr = 5'd9; #1;
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL wrap_load got %h want %h", rdata, e); else n_pass++;
    tick();
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL wrap_div got %h want %h", rdata, e); else n_pass++;
    tick();
    e = sb.pop_front(); n_chk++; if (rdata !== e) $display("FAIL wrap_zero got %h want %h", rdata, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_adel_eret();
    test_nested();
    test_masks();
    test_timer();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
